// File: rtl/id_ex_stage_reg_if.sv
// ID->EX bus: decode/register-file operands and control going in, EX-stage copies and
// the RAW hazard flag coming back out.
interface id_ex_stage_reg_if;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic [31:0] rn_val;
  logic [31:0] rm_val;
  logic [3:0]  dest;
  logic [8:0]  ctrl_in;
  logic [24:0] instr_in;
  logic [31:0] pc_in;
  logic [3:0]  status_in;

  logic        hazard;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_rn_val;
  logic [31:0] ex_rm_val;
  logic [3:0]  ex_dest;
  logic [3:0]  ex_src1;
  logic [3:0]  ex_src2;
  logic [24:0] ex_instr;
  logic [31:0] ex_pc;
  logic [3:0]  ex_status;

  modport master (
    output freeze, flush, id_valid, src1, src2, two_src, rn_val, rm_val, dest,
           ctrl_in, instr_in, pc_in, status_in,
    input  hazard, ex_valid, ex_ctrl, ex_rn_val, ex_rm_val, ex_dest, ex_src1, ex_src2,
           ex_instr, ex_pc, ex_status
  );

  modport slave (
    input  freeze, flush, id_valid, src1, src2, two_src, rn_val, rm_val, dest,
           ctrl_in, instr_in, pc_in, status_in,
    output hazard, ex_valid, ex_ctrl, ex_rn_val, ex_rm_val, ex_dest, ex_src1, ex_src2,
           ex_instr, ex_pc, ex_status
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with a two-entry (EX, MEM) destination scoreboard that
// detects RAW hazards and inserts bubbles while IF/ID is frozen.
module id_ex_stage_reg #(
  parameter bit FORWARD_EN = 1'b0
) (
  input logic               clk,
  input logic               rst,
  id_ex_stage_reg_if.slave  bus
);

  logic        vld_p1;
  logic [8:0]  ctrl_p1;
  logic [31:0] rn_val_p1;
  logic [31:0] rm_val_p1;
  logic [3:0]  dest_p1;
  logic [3:0]  src1_p1;
  logic [3:0]  src2_p1;
  logic [24:0] instr_p1;
  logic [31:0] pc_p1;
  logic [3:0]  status_p1;

  logic        vld_p2;
  logic [3:0]  dest_p2;
  logic        wb_en_p2;

  logic        hazard;

  // ctrl layout: [8]=wb_en, [7]=mem_r_en
  function automatic logic src_match(
    input logic [3:0] s,
    input logic       ex_v,
    input logic [3:0] ex_dest,
    input logic       ex_wb,
    input logic       ex_mr,
    input logic       mem_v,
    input logic [3:0] mem_dest,
    input logic       mem_wb
  );
    if (FORWARD_EN)
      return ex_v & ex_mr & (ex_dest == s);
    else
      return (ex_v & ex_wb & (ex_dest == s)) | (mem_v & mem_wb & (mem_dest == s));
  endfunction

  always_comb begin
    hazard = bus.id_valid &
      (src_match(bus.src1, vld_p1, dest_p1, ctrl_p1[8], ctrl_p1[7], vld_p2, dest_p2, wb_en_p2) |
       (bus.two_src &
        src_match(bus.src2, vld_p1, dest_p1, ctrl_p1[8], ctrl_p1[7], vld_p2, dest_p2, wb_en_p2)));
  end

  // ID -> EX (p1) and EX -> MEM scoreboard (p2)
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      ctrl_p1   <= '0;
      rn_val_p1 <= '0;
      rm_val_p1 <= '0;
      dest_p1   <= '0;
      src1_p1   <= '0;
      src2_p1   <= '0;
      instr_p1  <= '0;
      pc_p1     <= '0;
      status_p1 <= '0;
      vld_p2    <= 1'b0;
      dest_p2   <= '0;
      wb_en_p2  <= 1'b0;
    end else if (!bus.freeze) begin
      vld_p2   <= vld_p1;
      dest_p2  <= dest_p1;
      wb_en_p2 <= ctrl_p1[8];
      if (bus.flush || hazard || !bus.id_valid) begin
        vld_p1    <= 1'b0;
        ctrl_p1   <= '0;
        rn_val_p1 <= '0;
        rm_val_p1 <= '0;
        dest_p1   <= '0;
        src1_p1   <= '0;
        src2_p1   <= '0;
        instr_p1  <= '0;
        pc_p1     <= '0;
        status_p1 <= '0;
      end else begin
        vld_p1    <= 1'b1;
        ctrl_p1   <= bus.ctrl_in;
        rn_val_p1 <= bus.rn_val;
        rm_val_p1 <= bus.rm_val;
        dest_p1   <= bus.dest;
        src1_p1   <= bus.src1;
        src2_p1   <= bus.src2;
        instr_p1  <= bus.instr_in;
        pc_p1     <= bus.pc_in;
        status_p1 <= bus.status_in;
      end
    end
  end

  assign bus.hazard    = hazard;
  assign bus.ex_valid  = vld_p1;
  assign bus.ex_ctrl   = ctrl_p1;
  assign bus.ex_rn_val = rn_val_p1;
  assign bus.ex_rm_val = rm_val_p1;
  assign bus.ex_dest   = dest_p1;
  assign bus.ex_src1   = src1_p1;
  assign bus.ex_src2   = src2_p1;
  assign bus.ex_instr  = instr_p1;
  assign bus.ex_pc     = pc_p1;
  assign bus.ex_status = status_p1;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: one instance without forwarding (a) and one with
// forwarding (b), both fed the same ID-side stimulus.
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if a ();
  id_ex_stage_reg_if b ();

  assign b.freeze    = a.freeze;
  assign b.flush     = a.flush;
  assign b.id_valid  = a.id_valid;
  assign b.src1      = a.src1;
  assign b.src2      = a.src2;
  assign b.two_src   = a.two_src;
  assign b.rn_val    = a.rn_val;
  assign b.rm_val    = a.rm_val;
  assign b.dest      = a.dest;
  assign b.ctrl_in   = a.ctrl_in;
  assign b.instr_in  = a.instr_in;
  assign b.pc_in     = a.pc_in;
  assign b.status_in = a.status_in;

  id_ex_stage_reg #(.FORWARD_EN(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(a));
  id_ex_stage_reg #(.FORWARD_EN(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a.freeze = 0; a.flush = 0; a.id_valid = 0; a.src1 = 0; a.src2 = 0; a.two_src = 0;
    a.rn_val = 0; a.rm_val = 0; a.dest = 0; a.ctrl_in = 0; a.instr_in = 0; a.pc_in = 0;
    a.status_in = 0;
  endtask

  task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                       input logic [3:0] d, input logic [8:0] c);
    a.id_valid = 1; a.src1 = s1; a.src2 = s2; a.two_src = ts; a.dest = d; a.ctrl_in = c;
  endtask

  initial begin
    idle();
    rst = 0;
    issue(4'd0, 4'd0, 1'b0, 4'd3, 9'h100);
    a.rn_val = 32'hDEAD; a.pc_in = 32'h40; a.instr_in = 25'h1ABCDEF; a.status_in = 4'hF;
    // 1. reset
    step();
    chk("rst_ex_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("rst_ex_dest", {28'd0, a.ex_dest}, 32'd0);
    chk("rst_ex_ctrl", {23'd0, a.ex_ctrl}, 32'd0);
    chk("rst_ex_rn", a.ex_rn_val, 32'd0);
    chk("rst_ex_pc", a.ex_pc, 32'd0);
    chk("rst_ex_instr", {7'd0, a.ex_instr}, 32'd0);
    chk("rst_ex_status", {28'd0, a.ex_status}, 32'd0);
    chk("rst_hazard", {31'd0, a.hazard}, 32'd0);
    chk("rst_b_valid", {31'd0, b.ex_valid}, 32'd0);
    rst = 1;

    // 2. FWD=0 two-cycle stall; FWD=1 ADD producer no stall
    idle();
    issue(4'd0, 4'd0, 1'b0, 4'd3, 9'h100);
    a.rn_val = 32'h11; a.rm_val = 32'h22; a.pc_in = 32'h104; a.status_in = 4'h6;
    a.instr_in = 25'h0123456;
    #1;
    chk("prod_hazard", {31'd0, a.hazard}, 32'd0);
    step();
    chk("prod_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("prod_dest", {28'd0, a.ex_dest}, 32'd3);
    chk("prod_ctrl", {23'd0, a.ex_ctrl}, 32'h100);
    chk("prod_rn", a.ex_rn_val, 32'h11);
    chk("prod_rm", a.ex_rm_val, 32'h22);
    chk("prod_pc", a.ex_pc, 32'h104);
    chk("prod_status", {28'd0, a.ex_status}, 32'h6);
    chk("prod_instr", {7'd0, a.ex_instr}, 32'h0123456);
    issue(4'd3, 4'd0, 1'b0, 4'd5, 9'h100);
    #1;
    chk("raw_hazard_c0", {31'd0, a.hazard}, 32'd1);
    chk("fwd_add_nohaz", {31'd0, b.hazard}, 32'd0);
    step();
    chk("bubble1_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("raw_hazard_c1", {31'd0, a.hazard}, 32'd1);
    chk("fwd_add_issue", {28'd0, b.ex_dest}, 32'd5);
    chk("fwd_add_src1", {28'd0, b.ex_src1}, 32'd3);
    step();
    chk("bubble2_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("raw_hazard_c2", {31'd0, a.hazard}, 32'd0);
    step();
    chk("cons_valid", {31'd0, a.ex_valid}, 32'd1);
    chk("cons_dest", {28'd0, a.ex_dest}, 32'd5);

    // 3. FWD=1 load-use
    idle(); step(); step();
    issue(4'd0, 4'd0, 1'b0, 4'd4, 9'h180);
    step();
    issue(4'd0, 4'd4, 1'b1, 4'd6, 9'h100);
    #1;
    chk("ldu_hazard", {31'd0, b.hazard}, 32'd1);
    chk("ldu_a_hazard", {31'd0, a.hazard}, 32'd1);
    step();
    chk("ldu_bubble", {31'd0, b.ex_valid}, 32'd0);
    chk("ldu_hazard_off", {31'd0, b.hazard}, 32'd0);
    step();
    chk("ldu_issue_v", {31'd0, b.ex_valid}, 32'd1);
    chk("ldu_issue_d", {28'd0, b.ex_dest}, 32'd6);
    chk("ldu_issue_s2", {28'd0, b.ex_src2}, 32'd4);
    idle(); step(); step();
    issue(4'd0, 4'd0, 1'b0, 4'd4, 9'h180);
    step();
    issue(4'd0, 4'd4, 1'b0, 4'd6, 9'h100);
    #1;
    chk("ldu_onesrc_nohaz", {31'd0, b.hazard}, 32'd0);
    chk("ldu_onesrc_a", {31'd0, a.hazard}, 32'd0);

    // 4. flush kills ID instruction; previous EX dest moves to MEM
    idle(); step(); step();
    issue(4'd0, 4'd0, 1'b0, 4'd7, 9'h100);
    step();
    issue(4'd0, 4'd0, 1'b0, 4'd9, 9'h1FF);
    a.flush = 1;
    step();
    chk("flush_valid", {31'd0, a.ex_valid}, 32'd0);
    chk("flush_ctrl", {23'd0, a.ex_ctrl}, 32'd0);
    chk("flush_dest", {28'd0, a.ex_dest}, 32'd0);
    a.flush = 0;
    issue(4'd7, 4'd0, 1'b0, 4'd2, 9'h000);
    #1;
    chk("flush_mem_match", {31'd0, a.hazard}, 32'd1);
    chk("flush_mem_fwd", {31'd0, b.hazard}, 32'd0);

    // 5. freeze holds everything, flush ignored
    idle(); step(); step();
    issue(4'd0, 4'd0, 1'b0, 4'd8, 9'h100);
    a.rn_val = 32'hAAAA; a.pc_in = 32'h1234;
    step();
    a.freeze = 1; a.flush = 1;
    for (int i = 0; i < 3; i++) begin
      issue(4'd8, 4'(i), 1'b1, 4'(10 + i), 9'(9'h0F0 + i));
      a.rn_val = 32'h5500 + i; a.pc_in = 32'h9000 + i;
      #1;
      chk("frz_hazard", {31'd0, a.hazard}, 32'd1);
      step();
      chk("frz_valid", {31'd0, a.ex_valid}, 32'd1);
      chk("frz_dest", {28'd0, a.ex_dest}, 32'd8);
      chk("frz_rn", a.ex_rn_val, 32'hAAAA);
      chk("frz_pc", a.ex_pc, 32'h1234);
      chk("frz_ctrl", {23'd0, a.ex_ctrl}, 32'h100);
    end

    // 6. reset during a stall
    idle(); step(); step();
    issue(4'd0, 4'd0, 1'b0, 4'd3, 9'h100);
    step();
    issue(4'd3, 4'd0, 1'b0, 4'd5, 9'h100);
    #1;
    chk("rstst_hazard", {31'd0, a.hazard}, 32'd1);
    rst = 0;
    step();
    chk("rstst_hazard_clr", {31'd0, a.hazard}, 32'd0);
    chk("rstst_valid", {31'd0, a.ex_valid}, 32'd0);
    rst = 1;
    step();
    chk("rstst_issue_v", {31'd0, a.ex_valid}, 32'd1);
    chk("rstst_issue_d", {28'd0, a.ex_dest}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
